// File: rtl/prbs31_pkg.sv
// Shared PRBS31 constants, checker state type and saturating-increment helper.
package prbs31_pkg;

    localparam int unsigned TAP_A = 27;
    localparam int unsigned TAP_B = 30;
    localparam int unsigned LEN   = 31;

    typedef enum logic {
        SEARCH = 1'b0,
        LOCKED = 1'b1
    } state_t;

    // Increment v, holding at the all-ones value of a w-bit counter (w <= 32).
    function automatic logic [31:0] sat_inc(input logic [31:0] v, input int unsigned w);
        logic [31:0] max_v;
        max_v = (w >= 32) ? '1 : ((32'd1 << w) - 32'd1);
        return (v >= max_v) ? v : v + 32'd1;
    endfunction

endpackage

// File: rtl/prbs31_err_window.sv
// Loss-of-lock detector: counts errors per fixed window of locked bits and
// flags loss combinationally on the bit that brings the tally to threshold.
module prbs31_err_window #(
    parameter int unsigned WINDOW      = 256,
    parameter int unsigned LOSS_THRESH = 8
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    input  logic active,
    input  logic err,
    output logic loss
);

    localparam int unsigned WIN_W = $clog2(WINDOW);
    localparam int unsigned TAL_W = $clog2(WINDOW + 1);

    logic [WIN_W-1:0] win_cnt;
    logic [TAL_W-1:0] tally;
    logic [TAL_W-1:0] tally_nxt;
    logic             wrap;

    // Tally including this bit, window-end detection and loss decision.
    always_comb begin
        tally_nxt = tally + TAL_W'(err);
        wrap      = (win_cnt == WIN_W'(WINDOW - 1));
        loss      = active && en && (tally_nxt >= TAL_W'(LOSS_THRESH));
    end

    // Window position and tally; both held at zero outside LOCKED so entry starts clean.
    always_ff @(posedge clk) begin
        if (!rst_n || !active) begin
            win_cnt <= '0;
            tally   <= '0;
        end else if (en) begin
            win_cnt <= win_cnt + 1'b1;
            tally   <= (wrap || loss) ? '0 : tally_nxt;
        end
    end

endmodule

// File: rtl/prbs31_checker.sv
// PRBS31 (x^31 + x^28 + 1) serial checker: self-synchronises, flywheels once
// locked, counts bit errors and drops lock on excessive errors per window.
module prbs31_checker
    import prbs31_pkg::*;
#(
    parameter int unsigned LOCK_COUNT  = 64,
    parameter int unsigned WINDOW      = 256,
    parameter int unsigned LOSS_THRESH = 8,
    parameter int unsigned CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             din,
    input  logic             clr_cnt,
    output logic             locked,
    output logic             err_pulse,
    output logic [CNT_W-1:0] err_count,
    output logic [CNT_W-1:0] bit_count,
    output logic             lock_lost
);

    state_t         state;
    state_t         state_nxt;
    logic [LEN-1:0] r;
    logic [4:0]     fill_cnt;
    logic [7:0]     match_cnt;
    logic           p;
    logic           mismatch;
    logic           fill_done;
    logic           match_ok;
    logic           loss;

    assign p      = r[TAP_A] ^ r[TAP_B];
    assign locked = (state == LOCKED);

    prbs31_err_window #(
        .WINDOW      (WINDOW),
        .LOSS_THRESH (LOSS_THRESH)
    ) u_err_window (
        .clk    (clk),
        .rst_n  (rst_n),
        .en     (en),
        .active (locked),
        .err    (mismatch),
        .loss   (loss)
    );

    // Next-state: lock on the LOCK_COUNT-th consecutive match, unlock on window loss.
    always_comb begin
        mismatch  = (din != p);
        fill_done = (fill_cnt == 5'(LEN));
        match_ok  = !mismatch && (r != '0);
        state_nxt = state;
        if (state == SEARCH) begin
            if (en && fill_done && match_ok && (match_cnt == 8'(LOCK_COUNT - 1)))
                state_nxt = LOCKED;
        end else begin
            if (loss)
                state_nxt = SEARCH;
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n)
            state <= SEARCH;
        else
            state <= state_nxt;
    end

    // Shift register, search counters, error/bit counters and one-cycle flags.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r         <= '0;
            fill_cnt  <= '0;
            match_cnt <= '0;
            err_pulse <= 1'b0;
            lock_lost <= 1'b0;
            err_count <= '0;
            bit_count <= '0;
        end else begin
            err_pulse <= 1'b0;
            lock_lost <= 1'b0;
            if (en) begin
                if (state == SEARCH) begin
                    r <= {r[LEN-2:0], din};
                    if (!fill_done)
                        fill_cnt <= fill_cnt + 5'd1;
                    else if (match_ok)
                        match_cnt <= match_cnt + 8'd1;
                    else
                        match_cnt <= '0;
                    if (state_nxt == LOCKED) begin
                        fill_cnt  <= '0;
                        match_cnt <= '0;
                    end
                end else begin
                    r         <= {r[LEN-2:0], p};
                    bit_count <= CNT_W'(sat_inc(32'(bit_count), CNT_W));
                    if (mismatch) begin
                        err_pulse <= 1'b1;
                        err_count <= CNT_W'(sat_inc(32'(err_count), CNT_W));
                    end
                    if (loss) begin
                        lock_lost <= 1'b1;
                        fill_cnt  <= '0;
                        match_cnt <= '0;
                    end
                end
            end
            if (clr_cnt) begin
                err_count <= '0;
                bit_count <= '0;
            end
        end
    end

endmodule

// File: tb/tb_prbs31_checker.sv
// Self-checking bench for prbs31_checker: directed phases with randomized
// error placement and enables, checked against a queue-based reference model.
module tb_prbs31_checker;

    localparam int LOCK_COUNT  = 64;
    localparam int WINDOW      = 256;
    localparam int LOSS_THRESH = 8;
    localparam int CNT_W       = 16;
    localparam int CMAX        = (1 << CNT_W) - 1;

    logic        clk = 1'b0;
    logic        rst_n, en, din, clr_cnt;
    logic        locked, err_pulse, lock_lost;
    logic [15:0] err_count, bit_count;
    logic        s_en, s_din, s_clr;
    logic        s_locked, s_err_pulse, s_lock_lost;
    logic [3:0]  s_err_count, s_bit_count;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    prbs31_checker #(
        .LOCK_COUNT  (LOCK_COUNT),
        .WINDOW      (WINDOW),
        .LOSS_THRESH (LOSS_THRESH),
        .CNT_W       (CNT_W)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .din       (din),
        .clr_cnt   (clr_cnt),
        .locked    (locked),
        .err_pulse (err_pulse),
        .err_count (err_count),
        .bit_count (bit_count),
        .lock_lost (lock_lost)
    );

    prbs31_checker #(
        .LOCK_COUNT  (64),
        .WINDOW      (16),
        .LOSS_THRESH (16),
        .CNT_W       (4)
    ) dut_small (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (s_en),
        .din       (s_din),
        .clr_cnt   (s_clr),
        .locked    (s_locked),
        .err_pulse (s_err_pulse),
        .err_count (s_err_count),
        .bit_count (s_bit_count),
        .lock_lost (s_lock_lost)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_cmp++;
        assert (obs === exp_v) else begin
            n_bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp_v);
        end
    endtask

    // Transmitter streams: history of the last 31 sent bits, oldest first.
    bit g_hist[$];
    bit s_hist[$];

    function automatic bit gen_next();
        bit b;
        b = g_hist[0] ^ g_hist[3];
        void'(g_hist.pop_front());
        g_hist.push_back(b);
        return b;
    endfunction

    function automatic bit s_gen_next();
        bit b;
        b = s_hist[0] ^ s_hist[3];
        void'(s_hist.pop_front());
        s_hist.push_back(b);
        return b;
    endfunction

    // Reference model of the main checker.
    bit m_hist[$];
    int m_mode, m_fill, m_run, m_wpos, m_tally, m_errc, m_bitc;
    bit m_ep, m_ll;

    task automatic model_step(input bit e, input bit d, input bit c, input bit rst);
        bit pred, nz;
        if (rst) begin
            m_hist.delete();
            repeat (31) m_hist.push_back(1'b0);
            m_mode = 0; m_fill = 0; m_run = 0; m_wpos = 0; m_tally = 0;
            m_errc = 0; m_bitc = 0; m_ep = 0; m_ll = 0;
            return;
        end
        m_ep = 0;
        m_ll = 0;
        if (e) begin
            pred = m_hist[0] ^ m_hist[3];
            if (m_mode == 0) begin
                nz = 0;
                foreach (m_hist[i]) if (m_hist[i]) nz = 1;
                if (m_fill < 31) m_fill++;
                else if (d == pred && nz) begin
                    m_run++;
                    if (m_run == LOCK_COUNT) begin
                        m_mode = 1; m_run = 0; m_fill = 0; m_wpos = 0; m_tally = 0;
                    end
                end else m_run = 0;
                void'(m_hist.pop_front());
                m_hist.push_back(d);
            end else begin
                if (m_bitc < CMAX) m_bitc++;
                if (d != pred) begin
                    m_ep = 1;
                    if (m_errc < CMAX) m_errc++;
                    m_tally++;
                end
                m_wpos++;
                if (m_tally >= LOSS_THRESH) begin
                    m_mode = 0; m_ll = 1; m_tally = 0; m_wpos = 0; m_fill = 0; m_run = 0;
                end else if (m_wpos == WINDOW) begin
                    m_wpos = 0; m_tally = 0;
                end
                void'(m_hist.pop_front());
                m_hist.push_back(pred);
            end
        end
        if (c) begin
            m_errc = 0;
            m_bitc = 0;
        end
    endtask

    task automatic check_main(input string ph);
        chk({ph, ".locked"},    locked,    m_mode);
        chk({ph, ".err_pulse"}, err_pulse, m_ep);
        chk({ph, ".lock_lost"}, lock_lost, m_ll);
        chk({ph, ".err_count"}, err_count, m_errc);
        chk({ph, ".bit_count"}, bit_count, m_bitc);
    endtask

    task automatic cyc(input bit e, input bit d, input bit c);
        en = e; din = d; clr_cnt = c;
        s_en = 1'b0; s_din = 1'b0; s_clr = 1'b0;
        @(posedge clk);
        #1;
        model_step(e, d, c, 1'b0);
        check_main("cyc");
    endtask

    task automatic rst_cyc(input bit e);
        rst_n = 1'b0; en = e; din = 1'($urandom); clr_cnt = 1'b0;
        @(posedge clk);
        #1;
        model_step(e, din, 1'b0, 1'b1);
        check_main("reset");
        rst_n = 1'b1;
    endtask

    task automatic s_cyc(input bit d, input bit c);
        en = 1'b0; din = 1'b0; clr_cnt = 1'b0;
        s_en = 1'b1; s_din = d; s_clr = c;
        @(posedge clk);
        #1;
        model_step(1'b0, 1'b0, 1'b0, 1'b0);
        s_en = 1'b0;
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int  k, since, ep_cnt, pos, placed, mx;
        bit  ll_seen, b, e;
        bit  mask[50];
        int  ec0, bc0;

        repeat (31) g_hist.push_back(1'b1);
        repeat (31) s_hist.push_back(1'b1);
        rst_n = 1'b0; en = 1'b0; din = 1'b0; clr_cnt = 1'b0;
        s_en = 1'b0; s_din = 1'b0; s_clr = 1'b0;
        @(posedge clk);
        rst_cyc(1'b0);
        chk("reset.s_locked",    s_locked,    0);
        chk("reset.s_err_count", s_err_count, 0);

        // Small instance: saturation at 4 bits and clear-vs-increment.
        k = 0;
        while (!s_locked && k < 200) begin s_cyc(s_gen_next(), 1'b0); k++; end
        chk("s_lock_latency", k, 95);
        ep_cnt = 0;
        for (int i = 0; i < 60; i++) begin
            b = s_gen_next();
            s_cyc((i % 2 == 0) ? ~b : b, 1'b0);
            if (s_err_pulse) ep_cnt++;
            if (i == 19) chk("s_err_count_10", s_err_count, 10);
        end
        chk("s_err_sat",    s_err_count, 15);
        chk("s_bit_sat",    s_bit_count, 15);
        chk("s_pulses",     ep_cnt, 30);
        chk("s_still_lock", s_locked, 1);
        s_cyc(~s_gen_next(), 1'b1);
        chk("s_clr_err", s_err_count, 0);
        chk("s_clr_bit", s_bit_count, 0);
        chk("s_clr_pulse", s_err_pulse, 1);

        // Clean lock and long clean run.
        k = 0;
        while (!locked && k < 200) begin cyc(1'b1, gen_next(), 1'b0); k++; end
        chk("lock_latency", k, 95);
        repeat (10000) cyc(1'b1, gen_next(), 1'b0);
        chk("clean_err_count", err_count, 0);
        chk("clean_bit_count", bit_count, 10000);

        // One error per 100 bits at random offsets.
        ep_cnt = 0;
        for (int blk = 0; blk < 5; blk++) begin
            pos = $urandom_range(0, 99);
            for (int i = 0; i < 100; i++) begin
                b = gen_next();
                cyc(1'b1, (i == pos) ? ~b : b, 1'b0);
                if (err_pulse) ep_cnt++;
            end
        end
        chk("single_pulses", ep_cnt, 5);
        chk("single_err_count", err_count, 5);
        chk("single_locked", locked, 1);

        // Eight errors inside 50 bits at the start of a window.
        k = 0;
        while (m_wpos != 0 && k < WINDOW) begin cyc(1'b1, gen_next(), 1'b0); k++; end
        foreach (mask[i]) mask[i] = 0;
        placed = 0;
        while (placed < 8) begin
            pos = $urandom_range(0, 49);
            if (!mask[pos]) begin mask[pos] = 1; placed++; end
        end
        ll_seen = 0; since = 0;
        for (int i = 0; i < 50; i++) begin
            b = gen_next();
            cyc(1'b1, mask[i] ? ~b : b, 1'b0);
            if (ll_seen) since++;
            if (lock_lost) begin
                ll_seen = 1;
                chk("unlock_locked", locked, 0);
            end
        end
        chk("lock_lost_seen", ll_seen, 1);
        while (!locked && since < 300) begin cyc(1'b1, gen_next(), 1'b0); since++; end
        chk("relock_latency", since, 95);

        // clr_cnt coincident with an error.
        cyc(1'b1, ~gen_next(), 1'b1);
        chk("clr_err_count", err_count, 0);
        chk("clr_err_pulse", err_pulse, 1);

        // en low mid-lock.
        ec0 = m_errc; bc0 = m_bitc;
        repeat (20) begin
            cyc(1'b0, 1'($urandom), 1'b0);
            chk("en_low_pulse", err_pulse, 0);
        end
        chk("en_low_err", err_count, ec0);
        chk("en_low_bit", bit_count, bc0);

        // Randomized enables, sparse errors and occasional clears.
        for (int i = 0; i < 3000; i++) begin
            e = ($urandom_range(0, 7) != 0);
            b = e ? gen_next() : 1'($urandom);
            if (e && $urandom_range(0, 39) == 0) b = ~b;
            cyc(e, b, ($urandom_range(0, 499) == 0));
        end

        // Reset while locked, then relock.
        k = 0;
        while (!locked && k < 400) begin cyc(1'b1, gen_next(), 1'b0); k++; end
        chk("pre_reset_locked", locked, 1);
        repeat (5) cyc(1'b1, ~gen_next(), 1'b0);
        rst_cyc(1'b0);
        chk("mid_reset_locked", locked, 0);
        chk("mid_reset_err", err_count, 0);
        chk("mid_reset_bit", bit_count, 0);
        k = 0;
        while (!locked && k < 200) begin cyc(1'b1, gen_next(), 1'b0); k++; end
        chk("reset_relock_latency", k, 95);

        // All-zero line never locks and never builds a match run.
        rst_cyc(1'b1);
        mx = 0;
        repeat (1000) begin
            cyc(1'b1, 1'b0, 1'b0);
            if (int'(dut.match_cnt) > mx) mx = int'(dut.match_cnt);
        end
        chk("zero_locked", locked, 0);
        chk("zero_match_max", mx, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
